// File: rtl/spi_arb_pkg.sv
// ============================================================================
// Module   : spi_arb_pkg
// Purpose  : Shared types and constants for the SPI host-bound stream arbiter.
//            Holds the arbiter state encoding and the default source-ID
//            header base value.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_arb_pkg;

  // Arbiter states: IDLE arbitrates, HEADER emits the source-ID byte,
  // PAYLOAD passes the grantee's bytes straight through.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_HEADER  = 2'd1,
    ARB_PAYLOAD = 2'd2
  } arb_state_t;

  // Header byte base; the grantee index is OR-ed into its low bits.
  localparam logic [7:0] ARB_HDR_BASE_DEFAULT = 8'hF0;

endpackage : spi_arb_pkg

`default_nettype wire

// File: rtl/spi_stream_arbiter_rr_picker.sv
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational round-robin winner selection. Searches the request
//            vector starting one position above the previous winner, wrapping
//            around, so the previous winner has the lowest priority.
// Ports    : req_i        N-bit request vector
//            last_i       index of the previous winner
//            grant_idx_o  index of the winning request (0 when none)
//            any_req_o    high when at least one request is asserted
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] last_i,
  output logic [IDW-1:0] grant_idx_o,
  output logic           any_req_o
);

  logic           found;
  logic [IDW-1:0] cand;

  // Offsets 1..N visit every index once; offset N wraps back to last_i,
  // so the previous winner is only chosen when nobody else is asking.
  always_comb begin
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDW'((int'(last_i) + i) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        grant_idx_o = cand;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule : rr_picker

`default_nettype wire

// File: rtl/spi_stream_arbiter.sv
// ============================================================================
// Module   : spi_stream_arbiter
// Purpose  : Packet-atomic round-robin arbiter sharing the SPI slave's
//            host-bound stream input among NUM_REQ requesters. Optionally
//            prefixes each packet with a source-ID header byte and truncates
//            packets at MAX_PKT payload bytes.
// Ports    : clk_i          system clock
//            reset_i        asynchronous active-high reset
//            req_data_i     packed requester payloads, slice i = [i*WIDTH +: WIDTH]
//            req_vld_i      per-requester valid
//            req_last_i     per-requester end-of-packet marker
//            req_rdy_o      per-requester ready
//            out_data_o     byte to SPI slave write_data
//            out_vld_o      to SPI slave write_vld
//            out_rdy_i      from SPI slave write_rdy
//            grant_id_o     current or most recent grantee
//            busy_o         high whenever not IDLE
//            overrun_err_o  one-cycle pulse after a packet is truncated
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_stream_arbiter
  import spi_arb_pkg::*;
#(
  parameter  int               NUM_REQ   = 4,
  parameter  int               WIDTH     = 8,
  parameter  int               MAX_PKT   = 64,
  parameter  int               HEADER_EN = 1,
  parameter  logic [WIDTH-1:0] HDR_BASE  = WIDTH'(ARB_HDR_BASE_DEFAULT),
  localparam int               ID_BITS   = $clog2(NUM_REQ)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]         req_vld_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  output logic [NUM_REQ-1:0]         req_rdy_o,
  output logic [WIDTH-1:0]           out_data_o,
  output logic                       out_vld_o,
  input  logic                       out_rdy_i,
  output logic [ID_BITS-1:0]         grant_id_o,
  output logic                       busy_o,
  output logic                       overrun_err_o
);

  arb_state_t         state_q,      state_d;
  logic [ID_BITS-1:0] grant_id_q,   grant_id_d;
  logic [ID_BITS-1:0] last_grant_q, last_grant_d;
  logic [7:0]         byte_cnt_q,   byte_cnt_d;
  logic               overrun_q,    overrun_d;

  logic [ID_BITS-1:0] pick_idx;
  logic               pick_any;

  rr_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req_i       (req_vld_i),
    .last_i      (last_grant_q),
    .grant_idx_o (pick_idx),
    .any_req_o   (pick_any)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ARB_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= ID_BITS'(NUM_REQ - 1);
      byte_cnt_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      byte_cnt_q   <= byte_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    byte_cnt_d   = byte_cnt_q;
    overrun_d    = 1'b0;
    out_data_o   = '0;
    out_vld_o    = 1'b0;
    req_rdy_o    = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_idx;
          state_d    = (HEADER_EN != 0) ? ARB_HEADER : ARB_PAYLOAD;
        end
      end

      ARB_HEADER: begin
        out_vld_o  = 1'b1;
        out_data_o = HDR_BASE | WIDTH'(grant_id_q);
        if (out_rdy_i) begin
          state_d = ARB_PAYLOAD;
        end
      end

      ARB_PAYLOAD: begin
        // Zero-latency pass-through: the grantee sees the sink's ready directly.
        out_data_o            = req_data_i[int'(grant_id_q)*WIDTH +: WIDTH];
        out_vld_o             = req_vld_i[grant_id_q];
        req_rdy_o[grant_id_q] = out_rdy_i;
        if (req_vld_i[grant_id_q] && out_rdy_i) begin
          if (req_last_i[grant_id_q]) begin
            state_d      = ARB_IDLE;
            last_grant_d = grant_id_q;
            byte_cnt_d   = '0;
          end else if ((byte_cnt_q + 8'd1) == 8'(MAX_PKT)) begin
            // Truncate: the rest of the packet waits for a later grant.
            state_d      = ARB_IDLE;
            last_grant_d = grant_id_q;
            byte_cnt_d   = '0;
            overrun_d    = 1'b1;
          end else begin
            byte_cnt_d   = byte_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign grant_id_o    = grant_id_q;
  assign busy_o        = (state_q != ARB_IDLE);
  assign overrun_err_o = overrun_q;

endmodule : spi_stream_arbiter

`default_nettype wire

// File: tb/tb_spi_stream_arbiter.sv
// ============================================================================
// Module   : tb_spi_stream_arbiter
// Purpose  : Self-checking bench for spi_stream_arbiter (4 requesters,
//            MAX_PKT=4, header enabled). Expected output bytes are queued by
//            the stimulus; a monitor pops and compares each accepted byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_stream_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N*8-1:0] req_data;
  logic [N-1:0] req_vld, req_last, req_rdy;
  logic [7:0]   out_data;
  logic         out_vld, out_rdy;
  logic [1:0]   grant_id;
  logic         busy, ovr;

  always #5 clk = ~clk;

  spi_stream_arbiter #(
    .NUM_REQ   (N),
    .WIDTH     (8),
    .MAX_PKT   (4),
    .HEADER_EN (1),
    .HDR_BASE  (8'hF0)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_data_i    (req_data),
    .req_vld_i     (req_vld),
    .req_last_i    (req_last),
    .req_rdy_o     (req_rdy),
    .out_data_o    (out_data),
    .out_vld_o     (out_vld),
    .out_rdy_i     (out_rdy),
    .grant_id_o    (grant_id),
    .busy_o        (busy),
    .overrun_err_o (ovr)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [8:0] rq[N][$];       // {last, data} per requester
  bit         hold[N];
  bit         acc_flag[N];
  int         acc_cnt[N];
  int         ovr_cnt = 0;
  int         stall_cnt = 0;
  bit         stall_mode = 1'b0;
  int         stall_idx = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(string name);
    int c = 0;
    while (c < 400 && (exp_q.size() != 0 || busy || pending())) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(c < 400), 32'd1);
  endtask

  task automatic send(int r, logic [7:0] d, bit last);
    rq[r].push_back({last, d});
  endtask

  // Requester models and sink ready, updated just after each rising edge.
  initial begin
    req_vld  = '0;
    req_last = '0;
    req_data = '0;
    out_rdy  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc_flag[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        acc_flag[i] = 1'b0;
        if (rq[i].size() > 0 && !hold[i]) begin
          req_vld[i]        = 1'b1;
          req_data[i*8 +: 8] = rq[i][0][7:0];
          req_last[i]       = rq[i][0][8];
        end else begin
          req_vld[i]  = 1'b0;
          req_last[i] = 1'b0;
        end
      end
      if (stall_mode) begin
        out_rdy = (stall_idx % 4 == 0) || (stall_idx % 4 == 3);
        stall_idx++;
      end else begin
        out_rdy = 1'b1;
      end
    end
  end

  // Monitor: samples on the falling edge what the next rising edge will accept.
  initial begin
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    logic [7:0] ex;
    forever begin
      @(negedge clk);
      if (ovr) ovr_cnt++;
      for (int i = 0; i < N; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          acc_flag[i] = 1'b1;
          acc_cnt[i]++;
        end
      end
      if (prev_stall) begin
        stall_cnt++;
        check("stall_hold", {23'd0, out_vld, out_data}, {23'd0, 1'b1, prev_data});
      end
      prev_stall = out_vld && !out_rdy && !reset;
      prev_data  = out_data;
      if (out_vld && out_rdy && !reset) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream: got unexpected byte %0h expected none", out_data);
        end else begin
          ex = exp_q.pop_front();
          check("stream", 32'(out_data), 32'(ex));
        end
      end
    end
  end

  initial begin
    int  base;
    int  ovr_base;
    bit  found;

    repeat (3) @(negedge clk);
    check("rst_out_vld",  32'(out_vld),  32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_req_rdy",  32'(req_rdy),  32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_overrun",  32'(ovr),      32'd0);
    reset = 1'b0;

    // T1: single 3-byte packet from requester 2.
    base = acc_cnt[2];
    exp_q.push_back(8'hF2); exp_q.push_back(8'h11);
    exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    send(2, 8'h11, 0); send(2, 8'h22, 0); send(2, 8'h33, 1);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (out_vld && out_rdy && busy && out_data == 8'h33) found = 1'b1;
    end
    check("t1_last_seen", 32'(found), 32'd1);
    @(negedge clk);
    check("t1_busy_drop", 32'(busy), 32'd0);
    wait_drain("t1_drain");
    check("t1_rdy_count", 32'(acc_cnt[2] - base), 32'd3);

    // T2: all four requesters, two 1-byte packets each. Last grant was 2,
    // so requester 3 goes first, then strict rotation.
    for (int i = 0; i < N; i++) begin
      send(i, 8'(8'hA0 + i), 1);
      send(i, 8'(8'hB0 + i), 1);
    end
    exp_q.push_back(8'hF3); exp_q.push_back(8'hA3);
    exp_q.push_back(8'hF0); exp_q.push_back(8'hA0);
    exp_q.push_back(8'hF1); exp_q.push_back(8'hA1);
    exp_q.push_back(8'hF2); exp_q.push_back(8'hA2);
    exp_q.push_back(8'hF3); exp_q.push_back(8'hB3);
    exp_q.push_back(8'hF0); exp_q.push_back(8'hB0);
    exp_q.push_back(8'hF1); exp_q.push_back(8'hB1);
    exp_q.push_back(8'hF2); exp_q.push_back(8'hB2);
    wait_drain("t2_drain");

    // T3: 6-byte packet truncated at 4, remainder re-granted with new header.
    ovr_base = ovr_cnt;
    for (int k = 1; k <= 6; k++) send(1, 8'(8'h30 + k), k == 6);
    exp_q.push_back(8'hF1);
    exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    exp_q.push_back(8'h33); exp_q.push_back(8'h34);
    exp_q.push_back(8'hF1);
    exp_q.push_back(8'h35); exp_q.push_back(8'h36);
    wait_drain("t3_drain");
    check("t3_overrun_pulses", 32'(ovr_cnt - ovr_base), 32'd1);

    // T4: sink ready pattern 1,0,0,1 across header and payload.
    stall_mode = 1'b1;
    stall_idx  = 0;
    base = stall_cnt;
    send(0, 8'h41, 0); send(0, 8'h42, 0); send(0, 8'h43, 1);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h41);
    exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    wait_drain("t4_drain");
    stall_mode = 1'b0;
    check("t4_stalls_seen", 32'(stall_cnt > base), 32'd1);

    // T5: grantee 0 pauses mid-packet; requester 3 must wait. Last byte
    // lands exactly at MAX_PKT and is not an overrun.
    ovr_base = ovr_cnt;
    base = acc_cnt[0];
    send(0, 8'h51, 0); send(0, 8'h52, 0); send(0, 8'h53, 0); send(0, 8'h54, 1);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h51); exp_q.push_back(8'h52);
    exp_q.push_back(8'h53); exp_q.push_back(8'h54);
    exp_q.push_back(8'hF3); exp_q.push_back(8'h61);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (busy && grant_id == 2'd0) found = 1'b1;
    end
    check("t5_grant0", 32'(found), 32'd1);
    send(3, 8'h61, 1);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (acc_cnt[0] - base >= 2) found = 1'b1;
    end
    check("t5_two_bytes", 32'(found), 32'd1);
    hold[0] = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t5_held", {28'd0, out_vld, grant_id, req_rdy[3]}, {28'd0, 1'b0, 2'd0, 1'b0});
    end
    hold[0] = 1'b0;
    wait_drain("t5_drain");
    check("t5_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);

    // T6: async reset mid-PAYLOAD, then requester 0 must beat requester 3
    // (without reset, last grant 2 would favour requester 3).
    base = acc_cnt[2];
    send(2, 8'h71, 0); send(2, 8'h72, 0); send(2, 8'h73, 0); send(2, 8'h74, 1);
    exp_q.push_back(8'hF2); exp_q.push_back(8'h71);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (acc_cnt[2] - base >= 1) found = 1'b1;
    end
    check("t6_first_byte", 32'(found), 32'd1);
    hold[2] = 1'b1;
    @(posedge clk);
    #2;
    check("t6_busy_before", {30'd0, busy, grant_id == 2'd2}, {30'd0, 1'b1, 1'b1});
    #1;
    reset = 1'b1;
    #1;
    check("t6_rst_out_vld",  32'(out_vld),  32'd0);
    check("t6_rst_out_data", 32'(out_data), 32'd0);
    check("t6_rst_req_rdy",  32'(req_rdy),  32'd0);
    check("t6_rst_grant_id", 32'(grant_id), 32'd0);
    check("t6_rst_busy",     32'(busy),     32'd0);
    check("t6_rst_overrun",  32'(ovr),      32'd0);
    check("t6_queue_empty",  32'(exp_q.size()), 32'd0);
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      hold[i]     = 1'b0;
      acc_flag[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    send(0, 8'h81, 1);
    send(3, 8'h91, 1);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h81);
    exp_q.push_back(8'hF3); exp_q.push_back(8'h91);
    wait_drain("t6_drain");

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_spi_stream_arbiter

`default_nettype wire

// File: doc/spi_stream_arbiter.md
Name: spi_stream_arbiter

Overview:
- Shares the SPI slave's host-bound AXI-Stream input (write_data/write_vld/write_rdy) between NUM_REQ on-chip requesters, such as the core event output, status/telemetry, and the config readback.
- Grants are packet-atomic and round-robin, so packets from different requesters never interleave in the SPI read FIFO.
- Optionally prefixes each packet with a source-ID header byte so host software can demultiplex.
- Caps packet length to bound worst-case latency for the other requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID_BITS = $clog2(NUM_REQ).
- WIDTH, 8, byte width; must match the SPI slave WIDTH.
- MAX_PKT, 64, maximum payload bytes per grant (1..255).
- HEADER_EN, 1, 1 = emit header byte before each payload.
- HDR_BASE, 8'hF0, header value; low ID_BITS must be zero. Header = HDR_BASE | grant_id.

Ports:
- clk  in  1  system clock (the SPI slave's clk domain).
- reset  in  1  asynchronous, active-high reset.
- req_data  in  NUM_REQ*WIDTH  requester payloads; slice i = [i*WIDTH +: WIDTH].
- req_vld  in  NUM_REQ  per-requester valid.
- req_last  in  NUM_REQ  marks the final byte of a packet.
- req_rdy  out  NUM_REQ  per-requester ready.
- out_data  out  WIDTH  to SPI slave write_data.
- out_vld  out  1  to SPI slave write_vld.
- out_rdy  in  1  from SPI slave write_rdy.
- grant_id  out  ID_BITS  current or most recent grantee.
- busy  out  1  high in any state other than IDLE.
- overrun_err  out  1  one-cycle pulse when a packet is truncated at MAX_PKT.

Behaviour:
- Reset values (async assert): state=IDLE, out_vld=0, out_data=0, req_rdy=0, grant_id=0, busy=0, overrun_err=0, byte_cnt=0, last_grant=NUM_REQ-1 (so requester 0 wins first).
- States: IDLE, HEADER, PAYLOAD.
- IDLE:
  - out_vld=0 and req_rdy=0.
  - If any req_vld is high, register grant_id = first asserted index searching from last_grant+1 upward with wrap.
  - Next state is HEADER if HEADER_EN, else PAYLOAD. Arbitration costs exactly 1 cycle.
  - Requesters are only sampled in IDLE; a req_vld that drops before being sampled is ignored.
- HEADER:
  - out_vld=1, out_data=HDR_BASE|grant_id, req_rdy=0.
  - Hold until out_rdy, then go to PAYLOAD. Header bytes are not counted in byte_cnt.
- PAYLOAD (zero-latency pass-through):
  - out_data=req_data[grant_id], out_vld=req_vld[grant_id], req_rdy[grant_id]=out_rdy. All other req_rdy bits are 0.
  - A byte is accepted when out_vld & out_rdy; each accepted byte increments byte_cnt.
  - If the accepted byte has req_last=1: go to IDLE, set last_grant=grant_id, clear byte_cnt.
  - Else if byte_cnt+1 == MAX_PKT: same exit, plus overrun_err pulses the following cycle. The requester's remaining bytes become a new packet on a later grant.
  - A byte with last=1 exactly at MAX_PKT is normal: no error.
  - Grantee deasserting req_vld mid-packet: the grant is held indefinitely and out_vld is low. There is no timeout.
- Back-pressure: out_rdy low stalls the block; out_data/out_vld stay stable while out_vld=1 and out_rdy=0, in both HEADER and PAYLOAD.
- Packet-to-packet gap: at least 1 idle cycle (the IDLE arbitration cycle).
- Fairness: a requester that finishes a packet has the lowest priority at the next arbitration.
- Reset mid-packet: immediate return to reset values; the partial packet already in the SPI FIFO is not retracted. Host recovers via the SPI reset opcode.
- Widths: byte_cnt is 8 bits. out_data in IDLE is don't-care but is driven 0.

Decomposition:
- Package spi_arb_pkg holds the arb_state_t enum {ARB_IDLE, ARB_HEADER, ARB_PAYLOAD} and the default HDR_BASE constant.
- One combinational sub-module, rr_picker #(N): inputs req and last; outputs the one-hot/index winner and any_req. It is reusable for the read-side command dispatcher.

Test Plan:
- Single requester 2, HEADER_EN=1, 3-byte packet 0x11,0x22,0x33(last), out_rdy=1 -> out stream F2,11,22,33; req_rdy[2] high for exactly 3 accepted cycles; busy drops the cycle after 0x33.
- All 4 requesters continuously valid with 1-byte packets -> headers in order F0,F1,F2,F3,F0...; no requester is granted twice before all others are granted.
- MAX_PKT=4, requester 1 sends 6 bytes with last on byte 6 -> first grant carries 4 bytes then overrun_err pulses once; the next grant to requester 1 carries bytes 5-6 with a new header F1.
- out_rdy toggling 1,0,0,1 during header and payload -> out_data/out_vld stable while stalled; no bytes dropped or duplicated (scoreboard).
- Grantee drops req_vld for 5 cycles mid-packet while requester 3 is valid -> out_vld=0, grant held, requester 3 is not served until the grantee's last byte.
- Async reset asserted mid-PAYLOAD between clock edges -> all outputs are at reset values before the next clk edge; after release, requester 0 wins first arbitration.
